mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, is the cycles from the mem_enable cycle to valid mem_data_out; legal range 1..15.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request, held high until if_ack.
REQ-005 if_addr  input  16  fetch address.
REQ-006 if_ack  output  1  one-cycle pulse completing a fetch.
REQ-007 if_rdata  output  16  fetch data, valid while if_ack is high and held until the next fetch completes.
REQ-008 d_req  input  1  data-port request, held high until d_ack.
REQ-009 d_wr  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  16  data address.
REQ-011 d_wdata  input  16  store data.
REQ-012 d_ack  output  1  one-cycle pulse completing a data access.
REQ-013 d_rdata  output  16  load data, valid while d_ack is high and unchanged by stores.
REQ-014 mem_enable  output  1  memory access strobe.
REQ-015 mem_wr  output  1  memory write strobe.
REQ-016 mem_addr  output  16  memory address.
REQ-017 mem_data_in  output  16  write data to memory.
REQ-018 mem_data_out  input  16  read data from memory.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and RESP.
REQ-021 In IDLE, at a clock edge with any req high, the winner's addr, wr and wdata SHALL be latched and the FSM SHALL enter ISSUE.
REQ-022 Later changes on requester inputs SHALL NOT affect the transaction in flight.
REQ-023 ISSUE SHALL last one cycle, with mem_enable=1, mem_wr=latched wr, and mem_addr/mem_data_in driven from the latches.
REQ-024 After ISSUE the FSM SHALL stay in WAIT for LATENCY cycles using a 4-bit down-counter; mem_enable and mem_wr SHALL be 0 outside ISSUE.
REQ-025 On the last WAIT cycle, for a load, mem_data_out SHALL be captured into the winner's rdata register.
REQ-026 RESP SHALL last one cycle, with only the winner's ack high, and then return to IDLE.
REQ-027 Latency: a request sampled at edge T SHALL see ack high in cycle T+LATENCY+2 (cycle T+6 when LATENCY=4).
REQ-028 req SHALL be ignored in ISSUE, WAIT and RESP.
REQ-029 A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-030 Arbitration when both requests are high in IDLE is set by REQ-036/037; a lone requester SHALL always win.
REQ-031 At most one ack SHALL be high in any cycle; if_ack and d_ack SHALL never both be high.
REQ-032 The counter SHALL NOT wrap: WAIT exits exactly when the count reaches zero.

Reset
REQ-033 With rst high at an edge, the FSM SHALL go to IDLE, the counter and latches to 0, and if_rdata and d_rdata to 0x0000.
REQ-034 While rst is high, all outputs SHALL be 0, including if_ack, d_ack, busy, mem_enable, mem_wr, mem_addr and mem_data_in.
REQ-035 Reset in ISSUE, WAIT or RESP SHALL abort the transaction with no ack; the requester's held req SHALL be sampled as new in the first IDLE cycle after rst falls.

Configuration
REQ-036 Without ARB_ROUND_ROBIN_EN, the data port SHALL win every simultaneous request (fixed priority).
REQ-037 With ARB_ROUND_ROBIN_EN, a last-grant flag (reset = fetch) SHALL give a simultaneous request to the port not granted last, so the data port wins first after reset; the flag SHALL update on each grant.

Verification
REQ-038 LATENCY=4, if_req=1, if_addr=0x0010, mem_data_out=0xA5A5 -> mem_enable one cycle with addr 0x0010; if_ack at T+6; if_rdata=0xA5A5.
REQ-039 d_req=1, d_wr=1, d_addr=0x0200, d_wdata=0x1234 -> one cycle mem_enable=mem_wr=1 with addr 0x0200 and data 0x1234; d_ack at T+6; d_rdata unchanged.
REQ-040 Both requesters held for 3 transactions, macro off -> grants D,D,D; macro on -> grants D,I,D; never two acks in one cycle.
REQ-041 rst pulsed during WAIT of a load -> no ack, rdata=0x0000, busy=0; held req re-issues from IDLE and acks LATENCY+2 cycles after the first post-reset edge.
REQ-042 LATENCY=1 and LATENCY=15 back-to-back fetches -> ack spacing of LATENCY+3 cycles, and the WAIT count equals LATENCY.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the instruction-fetch port, the data port and the
// memory-side bus of mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the
// requesters' and memory's view.
interface mem_arbiter_if;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_ack;
   logic [15:0] if_rdata;

   logic        d_req;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic [15:0] d_rdata;

   logic        mem_enable;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_in;
   logic [15:0] mem_data_out;

   modport slave (
      input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
      output if_ack, if_rdata, d_ack, d_rdata, mem_enable, mem_wr, mem_addr, mem_data_in
   );

   modport master (
      output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
      input  if_ack, if_rdata, d_ack, d_rdata, mem_enable, mem_wr, mem_addr, mem_data_in
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto a
// single memory that has a fixed read latency.
// A transaction runs IDLE -> ISSUE -> WAIT (LATENCY cycles) -> RESP.
// The request is latched when it is granted, so requester inputs can change
// freely while the transaction is in flight.
// Optional feature macro ARB_ROUND_ROBIN_EN: simultaneous requests alternate
// between the two ports. Without the macro, the data port always wins.
module mem_arbiter #(
   parameter int LATENCY = 4   // cycles from mem_enable to valid mem_data_out, 1..15
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   // The WAIT counter runs LATENCY-1 down to 0, which gives exactly LATENCY WAIT cycles
   localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [15:0] addr_reg;
   logic [15:0] wdata_reg;
   logic        wr_reg;
   logic        sel_d_reg;      // port that owns the transaction in flight: 1 = data
   logic [15:0] if_rdata_reg;
   logic [15:0] d_rdata_reg;
   logic        any_req;
   logic        grant_d;
`ifdef ARB_ROUND_ROBIN_EN
   logic        last_d_reg;     // most recent grant went to the data port
`endif

   // Pick the winner from the requests seen in IDLE
   always_comb begin
      any_req = bus.if_req | bus.d_req;
`ifdef ARB_ROUND_ROBIN_EN
      grant_d = bus.d_req & (~bus.if_req | ~last_d_reg);
`else
      grant_d = bus.d_req;
`endif
   end

   // Next-state logic and the WAIT down-counter
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) state_next = ISSUE;
         end
         ISSUE: begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
         end
         WAIT: begin
            if (cnt_reg == 4'd0) state_next = RESP;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         RESP: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode; every output is forced to zero while rst is high
   always_comb begin
      busy            = 1'b0;
      bus.mem_enable  = 1'b0;
      bus.mem_wr      = 1'b0;
      bus.mem_addr    = 16'h0000;
      bus.mem_data_in = 16'h0000;
      bus.if_ack      = 1'b0;
      bus.d_ack       = 1'b0;
      bus.if_rdata    = 16'h0000;
      bus.d_rdata     = 16'h0000;
      if (!rst) begin
         busy            = (state_reg != IDLE);
         bus.mem_enable  = (state_reg == ISSUE);
         bus.mem_wr      = (state_reg == ISSUE) & wr_reg;
         bus.mem_addr    = addr_reg;
         bus.mem_data_in = wdata_reg;
         bus.if_ack      = (state_reg == RESP) & ~sel_d_reg;
         bus.d_ack       = (state_reg == RESP) &  sel_d_reg;
         bus.if_rdata    = if_rdata_reg;
         bus.d_rdata     = d_rdata_reg;
      end
   end

   // State register, request latches and read-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= 4'd0;
         addr_reg     <= 16'h0000;
         wdata_reg    <= 16'h0000;
         wr_reg       <= 1'b0;
         sel_d_reg    <= 1'b0;
         if_rdata_reg <= 16'h0000;
         d_rdata_reg  <= 16'h0000;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == IDLE && any_req) begin
            sel_d_reg <= grant_d;
            addr_reg  <= grant_d ? bus.d_addr : bus.if_addr;
            wr_reg    <= grant_d & bus.d_wr;
            wdata_reg <= grant_d ? bus.d_wdata : 16'h0000;
         end
         // Read data is valid on the last WAIT cycle; a store leaves both rdata registers alone
         if (state_reg == WAIT && cnt_reg == 4'd0 && !wr_reg) begin
            if (sel_d_reg) d_rdata_reg  <= bus.mem_data_out;
            else           if_rdata_reg <= bus.mem_data_out;
         end
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Last-grant flag: reset marks fetch as last, so the data port wins the first tie
   always_ff @(posedge clk) begin
      if (rst)                                last_d_reg <= 1'b0;
      else if (state_reg == IDLE && any_req) last_d_reg <= grant_d;
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// dut4  (LATENCY=4) runs against a timed memory model. The model returns
//       addr ^ 16'hA5B5 only on the cycle LATENCY cycles after mem_enable,
//       and 16'hDEAD on every other cycle.
// dut1  (LATENCY=1) and dut15 (LATENCY=15) run back-to-back fetches to
//       exercise the latency bounds.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

   localparam int L4 = 4;

   logic clk;
   logic rst;
   logic busy4, busy1, busy15;
   int   n_cmp;
   int   n_bad;

   mem_arbiter_if bus4 ();
   mem_arbiter_if bus1 ();
   mem_arbiter_if bus15 ();

   mem_arbiter #(.LATENCY(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4),  .busy(busy4));
   mem_arbiter #(.LATENCY(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1),  .busy(busy1));
   mem_arbiter #(.LATENCY(15)) dut15 (.clk(clk), .rst(rst), .bus(bus15), .busy(busy15));

   assign bus1.mem_data_out  = 16'h0F01;
   assign bus15.mem_data_out = 16'h0F01;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model for dut4: data appears only on the LATENCY-th cycle after the strobe
   int          pend;
   logic [15:0] paddr;
   always @(negedge clk) begin
      if (rst) begin
         pend              <= 0;
         bus4.mem_data_out <= 16'hDEAD;
      end else if (bus4.mem_enable) begin
         pend              <= L4 + 1;
         paddr             <= bus4.mem_addr;
         bus4.mem_data_out <= 16'hDEAD;
      end else if (pend == 2) begin
         pend              <= 1;
         bus4.mem_data_out <= paddr ^ 16'hA5B5;
      end else begin
         if (pend > 0) pend <= pend - 1;
         bus4.mem_data_out <= 16'hDEAD;
      end
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic test_reset();
      int         nz;
      logic [68:0] outs;
      nz = 0;
      // Requests raised during reset must be ignored
      bus4.if_req = 1'b1;
      bus4.d_req  = 1'b1;
      bus4.d_addr = 16'h7777;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         outs = {busy4, bus4.if_ack, bus4.d_ack, bus4.mem_enable, bus4.mem_wr,
                 bus4.mem_addr, bus4.mem_data_in, bus4.if_rdata, bus4.d_rdata};
         if (outs !== 69'd0) nz++;
      end
      n_cmp++;
      if (nz !== 0) begin n_bad++; $display("FAIL reset_outputs: %0d cycles with nonzero outputs, required 0", nz); end
      @(posedge clk); #1;
      bus4.if_req = 1'b0;
      bus4.d_req  = 1'b0;
      rst         = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy4); end
      n_cmp++;
      if (bus4.if_rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_if_rdata: got %h, required 0000", bus4.if_rdata); end
      n_cmp++;
      if (bus4.d_rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_d_rdata: got %h, required 0000", bus4.d_rdata); end
      $display("txn reset released, busy=%b", busy4);
   endtask

   // One isolated transaction on dut4. Requester inputs are scrambled right after the grant.
   task automatic test_single(input string tag, input bit is_d, input bit wr,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] exp_if_rdata, input logic [15:0] exp_d_rdata);
      int          en_n, en_j, ack_j, ack_n, wrong_ack, wr_stray;
      logic [15:0] en_addr, en_data, rd_at_ack, exp_rd;
      logic        en_wr, busy0;
      en_n = 0; en_j = -1; ack_j = -1; ack_n = 0; wrong_ack = 0; wr_stray = 0;
      en_addr = 16'h0; en_data = 16'h0; rd_at_ack = 16'h0; en_wr = 1'b0; busy0 = 1'b0;
      exp_rd = is_d ? exp_d_rdata : exp_if_rdata;
      @(posedge clk); #1;
      if (is_d) begin
         bus4.d_req = 1'b1; bus4.d_wr = wr; bus4.d_addr = addr; bus4.d_wdata = wdata;
      end else begin
         bus4.if_req = 1'b1; bus4.if_addr = addr;
      end
      @(posedge clk); #1;
      bus4.if_addr  = 16'hBEEF;
      bus4.d_addr   = 16'hBEEF;
      bus4.d_wdata  = 16'hBEEF;
      bus4.d_wr     = ~wr;
      for (int j = 0; j < L4 + 4; j++) begin
         @(negedge clk);
         if (j == 0) busy0 = busy4;
         if (bus4.mem_enable) begin
            en_n++; en_j = j; en_addr = bus4.mem_addr; en_data = bus4.mem_data_in; en_wr = bus4.mem_wr;
         end else if (bus4.mem_wr) begin
            wr_stray++;
         end
         if (is_d ? bus4.if_ack : bus4.d_ack) wrong_ack++;
         if (is_d ? bus4.d_ack : bus4.if_ack) begin
            ack_n++;
            if (ack_j < 0) begin
               ack_j     = j;
               rd_at_ack = is_d ? bus4.d_rdata : bus4.if_rdata;
            end
            bus4.if_req = 1'b0;
            bus4.d_req  = 1'b0;
         end
      end
      $display("txn %s addr=%h ack_cycle=%0d rdata=%h", tag, addr, ack_j, rd_at_ack);
      n_cmp++;
      if (busy0 !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b, required 1", tag, busy0); end
      n_cmp++;
      if (en_n !== 1) begin n_bad++; $display("FAIL %s_enable_count: got %0d, required 1", tag, en_n); end
      n_cmp++;
      if (en_j !== 0) begin n_bad++; $display("FAIL %s_enable_cycle: got %0d, required 0", tag, en_j); end
      n_cmp++;
      if (en_addr !== addr) begin n_bad++; $display("FAIL %s_mem_addr: got %h, required %h", tag, en_addr, addr); end
      n_cmp++;
      if (en_wr !== wr) begin n_bad++; $display("FAIL %s_mem_wr: got %b, required %b", tag, en_wr, wr); end
      if (wr) begin
         n_cmp++;
         if (en_data !== wdata) begin n_bad++; $display("FAIL %s_mem_data_in: got %h, required %h", tag, en_data, wdata); end
      end
      n_cmp++;
      if (wr_stray !== 0) begin n_bad++; $display("FAIL %s_stray_wr: got %0d, required 0", tag, wr_stray); end
      n_cmp++;
      if (ack_j !== L4 + 1) begin n_bad++; $display("FAIL %s_ack_cycle: got %0d, required %0d", tag, ack_j, L4 + 1); end
      n_cmp++;
      if (ack_n !== 1) begin n_bad++; $display("FAIL %s_ack_count: got %0d, required 1", tag, ack_n); end
      n_cmp++;
      if (wrong_ack !== 0) begin n_bad++; $display("FAIL %s_wrong_ack: got %0d, required 0", tag, wrong_ack); end
      n_cmp++;
      if (rd_at_ack !== exp_rd) begin n_bad++; $display("FAIL %s_rdata_at_ack: got %h, required %h", tag, rd_at_ack, exp_rd); end
      n_cmp++;
      if (busy4 !== 1'b0) begin n_bad++; $display("FAIL %s_idle_after: busy %b, required 0", tag, busy4); end
      n_cmp++;
      if (bus4.if_rdata !== exp_if_rdata) begin n_bad++; $display("FAIL %s_if_rdata_held: got %h, required %h", tag, bus4.if_rdata, exp_if_rdata); end
      n_cmp++;
      if (bus4.d_rdata !== exp_d_rdata) begin n_bad++; $display("FAIL %s_d_rdata_held: got %h, required %h", tag, bus4.d_rdata, exp_d_rdata); end
   endtask

   // Both ports are held high for three transactions after a fresh reset
   task automatic test_arbitration();
      logic [2:0]  seq, exp_seq;
      logic [15:0] exp_if;
      int          n, both, prev, gap_bad;
`ifdef ARB_ROUND_ROBIN_EN
      exp_seq = 3'b101;
      exp_if  = 16'hA5F5;
`else
      exp_seq = 3'b111;
      exp_if  = 16'h0000;
`endif
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      bus4.if_req = 1'b1; bus4.if_addr = 16'h0040;
      bus4.d_req  = 1'b1; bus4.d_wr = 1'b0; bus4.d_addr = 16'h0050;
      seq = 3'b000; n = 0; both = 0; prev = -1; gap_bad = 0;
      for (int j = 0; j < 40 && n < 3; j++) begin
         @(negedge clk);
         if (bus4.if_ack && bus4.d_ack) both++;
         if (bus4.if_ack || bus4.d_ack) begin
            seq[n] = bus4.d_ack;
            if (prev >= 0 && j - prev != L4 + 3) gap_bad++;
            $display("txn arb grant %0d to %s at cycle %0d", n, bus4.d_ack ? "D" : "I", j);
            prev = j;
            n++;
            if (n == 3) begin
               bus4.if_req = 1'b0;
               bus4.d_req  = 1'b0;
            end
         end
      end
      n_cmp++;
      if (n !== 3) begin n_bad++; $display("FAIL arb_ack_count: got %0d acks, required 3", n); end
      n_cmp++;
      if (seq !== exp_seq) begin n_bad++; $display("FAIL arb_grant_order: got %b, required %b (bit0 first, 1=D)", seq, exp_seq); end
      n_cmp++;
      if (both !== 0) begin n_bad++; $display("FAIL arb_double_ack: got %0d cycles, required 0", both); end
      n_cmp++;
      if (gap_bad !== 0) begin n_bad++; $display("FAIL arb_ack_spacing: %0d gaps off, required 0", gap_bad); end
      @(negedge clk);
      n_cmp++;
      if (bus4.d_rdata !== 16'hA5E5) begin n_bad++; $display("FAIL arb_d_rdata: got %h, required a5e5", bus4.d_rdata); end
      n_cmp++;
      if (bus4.if_rdata !== exp_if) begin n_bad++; $display("FAIL arb_if_rdata: got %h, required %h", bus4.if_rdata, exp_if); end
   endtask

   // Reset hits a load in WAIT; the held request must restart cleanly
   task automatic test_reset_abort();
      int          ack_n, ack_j;
      logic        busy_w;
      logic [68:0] outs;
      ack_n = 0; ack_j = -1;
      @(posedge clk); #1;
      bus4.d_req = 1'b1; bus4.d_wr = 1'b0; bus4.d_addr = 16'h0123;
      @(posedge clk);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         if (bus4.d_ack || bus4.if_ack) ack_n++;
      end
      busy_w = busy4;
      n_cmp++;
      if (busy_w !== 1'b1) begin n_bad++; $display("FAIL abort_busy_in_wait: got %b, required 1", busy_w); end
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      outs = {busy4, bus4.if_ack, bus4.d_ack, bus4.mem_enable, bus4.mem_wr,
              bus4.mem_addr, bus4.mem_data_in, bus4.if_rdata, bus4.d_rdata};
      n_cmp++;
      if (outs !== 69'd0) begin n_bad++; $display("FAIL abort_outputs_in_rst: got %h, required 0", outs); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      if (bus4.d_ack || bus4.if_ack) ack_n++;
      n_cmp++;
      if (busy4 !== 1'b0) begin n_bad++; $display("FAIL abort_busy_after: got %b, required 0", busy4); end
      n_cmp++;
      if (bus4.d_rdata !== 16'h0000) begin n_bad++; $display("FAIL abort_d_rdata_cleared: got %h, required 0000", bus4.d_rdata); end
      @(posedge clk);
      for (int j = 0; j < 12 && ack_j < 0; j++) begin
         @(negedge clk);
         if (bus4.if_ack) ack_n++;
         if (bus4.d_ack) begin
            ack_j = j;
            bus4.d_req = 1'b0;
         end
      end
      $display("txn reissued load addr=0123 ack_cycle=%0d rdata=%h", ack_j, bus4.d_rdata);
      n_cmp++;
      if (ack_n !== 0) begin n_bad++; $display("FAIL abort_stray_ack: got %0d, required 0", ack_n); end
      n_cmp++;
      if (ack_j !== L4 + 1) begin n_bad++; $display("FAIL abort_reissue_ack_cycle: got %0d, required %0d", ack_j, L4 + 1); end
      n_cmp++;
      if (bus4.d_rdata !== 16'hA496) begin n_bad++; $display("FAIL abort_reissue_rdata: got %h, required a496", bus4.d_rdata); end
   endtask

   // Back-to-back fetches at LATENCY=1 and LATENCY=15
   task automatic test_latency_bounds();
      int a1[3];
      int a15[3];
      int n1, n15, w1, w15;
      n1 = 0; n15 = 0; w1 = 0; w15 = 0;
      for (int k = 0; k < 3; k++) begin a1[k] = -100; a15[k] = -100; end
      @(posedge clk); #1;
      bus1.if_req = 1'b1;  bus1.if_addr = 16'h0101;
      bus15.if_req = 1'b1; bus15.if_addr = 16'h1515;
      @(posedge clk);
      for (int j = 0; j < 70; j++) begin
         @(negedge clk);
         if (n1 == 1 && busy1 && !bus1.mem_enable && !bus1.if_ack) w1++;
         if (n15 == 1 && busy15 && !bus15.mem_enable && !bus15.if_ack) w15++;
         if (bus1.if_ack && n1 < 3) begin
            a1[n1] = j; n1++;
            $display("txn lat1 fetch %0d ack_cycle=%0d rdata=%h", n1, j, bus1.if_rdata);
         end
         if (bus15.if_ack && n15 < 3) begin
            a15[n15] = j; n15++;
            $display("txn lat15 fetch %0d ack_cycle=%0d rdata=%h", n15, j, bus15.if_rdata);
         end
      end
      bus1.if_req  = 1'b0;
      bus15.if_req = 1'b0;
      n_cmp++;
      if (a1[0] !== 2) begin n_bad++; $display("FAIL lat1_first_ack: got %0d, required 2", a1[0]); end
      n_cmp++;
      if (a1[1] - a1[0] !== 4) begin n_bad++; $display("FAIL lat1_spacing_a: got %0d, required 4", a1[1] - a1[0]); end
      n_cmp++;
      if (a1[2] - a1[1] !== 4) begin n_bad++; $display("FAIL lat1_spacing_b: got %0d, required 4", a1[2] - a1[1]); end
      n_cmp++;
      if (w1 !== 1) begin n_bad++; $display("FAIL lat1_wait_cycles: got %0d, required 1", w1); end
      n_cmp++;
      if (bus1.if_rdata !== 16'h0F01) begin n_bad++; $display("FAIL lat1_rdata: got %h, required 0f01", bus1.if_rdata); end
      n_cmp++;
      if (a15[0] !== 16) begin n_bad++; $display("FAIL lat15_first_ack: got %0d, required 16", a15[0]); end
      n_cmp++;
      if (a15[1] - a15[0] !== 18) begin n_bad++; $display("FAIL lat15_spacing_a: got %0d, required 18", a15[1] - a15[0]); end
      n_cmp++;
      if (a15[2] - a15[1] !== 18) begin n_bad++; $display("FAIL lat15_spacing_b: got %0d, required 18", a15[2] - a15[1]); end
      n_cmp++;
      if (w15 !== 15) begin n_bad++; $display("FAIL lat15_wait_cycles: got %0d, required 15", w15); end
      n_cmp++;
      if (bus15.if_rdata !== 16'h0F01) begin n_bad++; $display("FAIL lat15_rdata: got %h, required 0f01", bus15.if_rdata); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      bus4.if_req = 1'b0;  bus4.if_addr = 16'h0;  bus4.d_req = 1'b0;  bus4.d_wr = 1'b0;
      bus4.d_addr = 16'h0; bus4.d_wdata = 16'h0;
      bus1.if_req = 1'b0;  bus1.if_addr = 16'h0;  bus1.d_req = 1'b0;  bus1.d_wr = 1'b0;
      bus1.d_addr = 16'h0; bus1.d_wdata = 16'h0;
      bus15.if_req = 1'b0; bus15.if_addr = 16'h0; bus15.d_req = 1'b0; bus15.d_wr = 1'b0;
      bus15.d_addr = 16'h0; bus15.d_wdata = 16'h0;

      test_reset();
      test_single("fetch", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 16'h0000);
      test_single("load",  1'b1, 1'b0, 16'h0300, 16'h0000, 16'hA5A5, 16'hA6B5);
      test_single("store", 1'b1, 1'b1, 16'h0200, 16'h1234, 16'hA5A5, 16'hA6B5);
      test_arbitration();
      test_reset_abort();
      test_latency_bounds();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
